incr_button_conditioner: RTL
============================

Name: incr_button_conditioner

Overview:
Upstream conditioner for the up-counter's increment input. It converts a raw, bouncy, asynchronous push-button into clean single-cycle increment pulses in the BrdClk domain. It provides:
- metastability synchronization;
- symmetric press/release debounce;
- an optional hold-to-auto-repeat function.

bIncrPulse drives the counter's aIncrement input directly.

Parameters:
SYNC_STAGES, 2, synchronizer flop depth (legal range >=2).
DEBOUNCE_CYCLES, 1000000, consecutive mismatching cycles needed to accept a level change (>=1; 10 ms at 100 MHz).
REPEAT_DELAY_CYCLES, 50000000, cycles from the first pulse to the first auto-repeat pulse (>=2).
REPEAT_RATE_CYCLES, 20000000, cycles between successive auto-repeat pulses (>=2).

Ports:
BrdClk  input  1  board clock; all state is on its rising edge.
aReset  input  1  asynchronous, active-high reset.
aButton  input  1  raw asynchronous button level, 1 = pressed.
bRepeatEn  input  1  1 = auto-repeat allowed while held; sampled every cycle.
bPressed  output  1  debounced button level (registered).
bIncrPulse  output  1  one-cycle increment strobe (registered).
bRepeating  output  1  high while the FSM is in the REPEAT state.

Behaviour:
Reset:
- aReset=1 asynchronously clears all state: synchronizer flops=0, debounce counter=0, bPressed=0, bIncrPulse=0, bRepeating=0, FSM=IDLE, repeat timer=0.
- If the button is held through reset deassertion, it is treated as a new press: one pulse after the full debounce latency.

Synchronizer:
- aButton passes through SYNC_STAGES flops; the last stage is bSync.
- No other logic samples aButton.

Debounce:
- The counter increments each cycle while bSync != bPressed.
- The counter clears to 0 in any cycle where bSync == bPressed.
- In the cycle the counter == DEBOUNCE_CYCLES-1 and bSync != bPressed still holds, bPressed toggles at the next edge and the counter clears.
- Any glitch shorter than DEBOUNCE_CYCLES cycles produces no change.
- Latency: with aButton stable from edge 0, bPressed changes at edge SYNC_STAGES+DEBOUNCE_CYCLES.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).

FSM (states IDLE, HOLD, REPEAT; a single repeat timer, width from the larger of the two repeat parameters):
- IDLE: on bPressed 0->1, pulse the next cycle, go to HOLD, timer=0.
- HOLD: if bPressed=0, go to IDLE with no pulse. Else, if bRepeatEn=1 and timer==REPEAT_DELAY_CYCLES-1, pulse, go to REPEAT, timer=0. Else, timer increments.
- HOLD with bRepeatEn=0: the timer holds at 0.
- REPEAT: if bPressed=0, go to IDLE. Else, if bRepeatEn=0, go to HOLD with timer=0. Else, if timer==REPEAT_RATE_CYCLES-1, pulse and timer=0. Else, timer increments.

Pulse timing:
- bIncrPulse is high for exactly 1 cycle per event. It is never high in two consecutive cycles, given the parameter minimums above.
- First pulse: the cycle after edge SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Repeat pulses: P+REPEAT_DELAY_CYCLES, then every REPEAT_RATE_CYCLES thereafter, where P is the edge the first pulse asserts.

Simultaneous events:
- Release and timer expiry in the same cycle: release wins, no pulse.
- bRepeatEn falling on a timer-expiry cycle: no pulse.
- bRepeatEn rising in HOLD: the delay restarts from 0.

Other rules:
- Release never generates a pulse.
- Reset mid-hold aborts immediately; bIncrPulse drops asynchronously.

Test Plan (bench parameters SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=10, REPEAT_RATE_CYCLES=3):
1. Clean press: aButton 0->1 before edge 0, held, bRepeatEn=0 -> bPressed=1 at edge 6; bIncrPulse high only between edges 7 and 8; no further pulses over 50 cycles; bRepeating=0.
2. Bounce rejection: aButton toggles with 1-3 cycle highs for 30 cycles, then settles at 0 -> bPressed stays 0, zero pulses. Then a stable press -> exactly 1 pulse.
3. Auto-repeat: press held, bRepeatEn=1, first pulse at edge 7 -> pulses at edges 7, 17, 20, 23, 26; bRepeating=1 from edge 17. Release -> bPressed=0 four cycles after the sync delay; FSM returns to IDLE; no release pulse.
4. Release races expiry: in REPEAT, time the debounced fall to the same cycle the rate timer expires -> no pulse; FSM=IDLE; bRepeating=0.
5. Repeat disable: in REPEAT, drop bRepeatEn for 5 cycles, then raise it -> no pulses while low; next pulse 10 cycles after the rise.
6. Reset mid-hold: assert aReset between edges 18 and 19 while held -> all outputs 0 immediately. Deassert with the button still held -> one new pulse 7 cycles later.

Source files
------------

// File: rtl/incr_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : incr_button_conditioner
// Purpose  : Turns a raw, bouncy, asynchronous push-button into clean
//            single-cycle increment strobes in the BrdClk domain, with
//            synchronization, symmetric debounce and optional hold-to-repeat.
// Ports    : BrdClk     - board clock, all state on its rising edge
//            aReset     - asynchronous active-high reset
//            aButton    - raw button level, 1 = pressed
//            bRepeatEn  - 1 = auto-repeat allowed while held
//            bPressed   - debounced button level (registered)
//            bIncrPulse - one-cycle increment strobe (registered)
//            bRepeating - high while the auto-repeat state is active
// Revision : 1.0 - initial release
// ============================================================================
module incr_button_conditioner #(
    parameter int SYNC_STAGES         = 2,
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int REPEAT_DELAY_CYCLES = 50000000,
    parameter int REPEAT_RATE_CYCLES  = 20000000
) (
    input  logic BrdClk,
    input  logic aReset,
    input  logic aButton,
    input  logic bRepeatEn,
    output logic bPressed,
    output logic bIncrPulse,
    output logic bRepeating
);

    localparam int c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_TMR_MAX = (REPEAT_DELAY_CYCLES > REPEAT_RATE_CYCLES) ?
                               REPEAT_DELAY_CYCLES : REPEAT_RATE_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX);

    localparam logic [c_CNT_W-1:0] c_DB_LAST    = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LAST = c_TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_RATE_LAST  = c_TMR_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q,    sync_d;
    logic [c_CNT_W-1:0]     db_cnt_q,  db_cnt_d;
    logic                   pressed_q, pressed_d;
    state_t                 state_q,   state_d;
    logic [c_TMR_W-1:0]     timer_q,   timer_d;
    logic                   pulse_q,   pulse_d;
    logic                   w_sync;

    // ------------------------------------------------------------------
    // Synchronizer: aButton is sampled nowhere else.
    // ------------------------------------------------------------------
    assign w_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], aButton};
    end

    // ------------------------------------------------------------------
    // Debounce: the level is accepted only after DEBOUNCE_CYCLES
    // consecutive mismatching cycles; any agreeing cycle restarts the run.
    // ------------------------------------------------------------------
    always_comb begin
        pressed_d = pressed_q;
        db_cnt_d  = '0;
        if (w_sync != pressed_q) begin
            if (db_cnt_q == c_DB_LAST) begin
                pressed_d = ~pressed_q;
            end else begin
                db_cnt_d = db_cnt_q + c_CNT_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pulse / auto-repeat FSM. Release is tested first so that a release
    // landing on a timer expiry never produces a strobe.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pulse_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                // IDLE is only ever entered with the level low, so a high
                // level seen here is always a fresh press.
                if (pressed_q) begin
                    pulse_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (!bRepeatEn) begin
                    // Keeping the timer at zero makes the delay restart
                    // from scratch when repeat is re-enabled.
                    timer_d = '0;
                end else if (timer_q == c_DELAY_LAST) begin
                    pulse_d = 1'b1;
                    state_d = ST_REPEAT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + c_TMR_ONE;
                end
            end
            ST_REPEAT: begin
                if (!pressed_q) begin
                    state_d = ST_IDLE;
                    timer_d = '0;
                end else if (!bRepeatEn) begin
                    state_d = ST_HOLD;
                    timer_d = '0;
                end else if (timer_q == c_RATE_LAST) begin
                    pulse_d = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + c_TMR_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge BrdClk or posedge aReset) begin
        if (aReset) begin
            sync_q    <= '0;
            db_cnt_q  <= '0;
            pressed_q <= 1'b0;
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            db_cnt_q  <= db_cnt_d;
            pressed_q <= pressed_d;
            state_q   <= state_d;
            timer_q   <= timer_d;
            pulse_q   <= pulse_d;
        end
    end

    assign bPressed   = pressed_q;
    assign bIncrPulse = pulse_q;
    assign bRepeating = (state_q == ST_REPEAT);

endmodule
`default_nettype wire
